// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC sequencing, I-cache request handshake and IF/ID register
// Holds one fetched instruction across a pipeline stall; drains wrong-path responses after a redirect.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_rdata,
  input  logic        icache_resp,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        fetch_stall
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic        valid_out_q, valid_out_d;
  logic        flush;
  logic        delivered;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    pc_out_d     = pc_out_q;
    instr_out_d  = instr_out_q;
    valid_out_d  = valid_out_q;
    flush        = 1'b0;
    delivered    = 1'b0;

    case (state_q)
      FETCH: begin
        req_addr_d = pc_q;
        if (br_en) begin
          flush   = 1'b1;
          pc_d    = br_target;
          // A redirect with the read still in flight must wait out the stale response.
          state_d = icache_resp ? FETCH : DRAIN;
        end else if (icache_resp) begin
          pc_d = pc_q + 32'd4;
          if (stall_in) begin
            hold_pc_d    = pc_q;
            hold_instr_d = icache_rdata;
            state_d      = HOLD;
          end else begin
            pc_out_d    = pc_q;
            instr_out_d = icache_rdata;
            valid_out_d = 1'b1;
            delivered   = 1'b1;
          end
        end else if (!stall_in) begin
          flush = 1'b1;
        end
      end
      DRAIN: begin
        if (br_en) begin
          flush = 1'b1;
          pc_d  = br_target;
        end
        if (icache_resp) state_d = FETCH;
      end
      HOLD: begin
        if (br_en) begin
          flush   = 1'b1;
          pc_d    = br_target;
          state_d = FETCH;
        end else if (!stall_in) begin
          pc_out_d    = hold_pc_q;
          instr_out_d = hold_instr_q;
          valid_out_d = 1'b1;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (flush) begin
      pc_out_d    = 32'd0;
      instr_out_d = NOP_INSTR;
      valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_pc_q    <= 32'd0;
      hold_instr_q <= 32'd0;
      pc_out_q     <= 32'd0;
      instr_out_q  <= NOP_INSTR;
      valid_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      pc_out_q     <= pc_out_d;
      instr_out_q  <= instr_out_d;
      valid_out_q  <= valid_out_d;
    end
  end

  assign icache_read     = !rst && (state_q != HOLD);
  assign icache_address  = (state_q == DRAIN) ? req_addr_q : pc_q;
  assign fetch_stall     = (state_q != HOLD) && !delivered;
  assign PC_out          = pc_out_q;
  assign instruction_out = instr_out_q;
  assign valid_out       = valid_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized bench for instruction_fetch with a latency-varying I-cache
// Expected values come from a transaction-level model: outstanding request, wrong-path flag, hold queue.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        br_en;
  logic [31:0] br_target;
  logic        icache_read;
  logic [31:0] icache_address;
  logic [31:0] icache_rdata;
  logic        icache_resp;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        fetch_stall;

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .br_en           (br_en),
    .br_target       (br_target),
    .icache_read     (icache_read),
    .icache_address  (icache_address),
    .icache_rdata    (icache_rdata),
    .icache_resp     (icache_resp),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .fetch_stall     (fetch_stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_req, m_pc_out, m_instr;
  logic        m_valid, m_drain;
  logic [63:0] held_q[$];

  // I-cache model state
  bit pend;
  int cnt;
  int force_lat = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic bubble();
    m_pc_out = 32'd0;
    m_instr  = 32'h0000_0013;
    m_valid  = 1'b0;
  endtask

  task automatic model_update(input bit r, input bit s, input bit b, input logic [31:0] t,
                              input bit resp, input logic [31:0] rdata);
    logic [63:0] e;
    if (r) begin
      m_pc = 32'h60; m_req = 32'h60; m_drain = 1'b0; held_q.delete(); bubble();
    end else if (held_q.size() != 0) begin
      if (b) begin
        held_q.delete(); m_pc = t; bubble();
      end else if (!s) begin
        e = held_q.pop_front();
        m_pc_out = e[63:32]; m_instr = e[31:0]; m_valid = 1'b1;
      end
    end else if (m_drain) begin
      if (b) begin m_pc = t; bubble(); end
      if (resp) m_drain = 1'b0;
    end else begin
      if (b) begin
        bubble();
        if (!resp) begin m_drain = 1'b1; m_req = m_pc; end
        m_pc = t;
      end else if (resp) begin
        if (s) held_q.push_back({m_pc, rdata});
        else begin m_pc_out = m_pc; m_instr = rdata; m_valid = 1'b1; end
        m_pc = m_pc + 32'd4;
      end else if (!s) begin
        bubble();
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    bit          exp_read, deliver;
    logic [31:0] exp_addr;
    rst = r; stall_in = s; br_en = b; br_target = t;
    icache_resp = 1'b0; icache_rdata = 32'd0;
    #1;
    exp_read = !r && (held_q.size() == 0);
    exp_addr = m_drain ? m_req : m_pc;
    check("icache_read", {31'd0, icache_read}, {31'd0, exp_read});
    if (exp_read) check("icache_address", icache_address, exp_addr);
    if (r) pend = 1'b0;
    else if (exp_read) begin
      if (!pend) begin
        pend = 1'b1;
        if (force_lat >= 0) cnt = force_lat;
        else cnt = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      end
      if (cnt == 0) begin
        icache_resp = 1'b1; icache_rdata = mem_word(exp_addr); pend = 1'b0;
      end else cnt--;
    end
    #1;
    if (!r) begin
      deliver = (held_q.size() == 0) && !m_drain && icache_resp && !b && !s;
      check("fetch_stall", {31'd0, fetch_stall}, {31'd0, (held_q.size() == 0) && !deliver});
    end
    model_update(r, s, b, t, icache_resp, icache_rdata);
    @(posedge clk); #1;
    check("PC_out", PC_out, m_pc_out);
    check("instruction_out", instruction_out, m_instr);
    check("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
  endtask

  initial begin
    logic [31:0] tgt;
    bit          r, s, b;
    rst = 1'b1; stall_in = 1'b0; br_en = 1'b0; br_target = 32'd0;
    icache_resp = 1'b0; icache_rdata = 32'd0;
    m_pc = 32'h60; m_req = 32'h60; m_drain = 1'b0; bubble();
    @(posedge clk); #1;

    // Reset then back-to-back single-cycle fetches from 0x60
    force_lat = 0;
    step(1, 0, 0, 0);
    check("reset_instr", instruction_out, 32'h0000_0013);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("seq_pc_0x68", PC_out, 32'h68);

    // Redirect while a slow request is outstanding
    force_lat = 3;
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h200);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // Stall with an instruction in hand, then release; then redirect out of HOLD
    force_lat = 0;
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h100);
    check("hold_flush_valid", {31'd0, valid_out}, 32'd0);
    step(0, 0, 0, 0);

    // PC wrap at the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_pc_out", PC_out, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_next_pc", PC_out, 32'h0);

    // Reset with a request outstanding
    force_lat = 3;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic
    force_lat = -1;
    tgt = 32'h400;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      if (b && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        else tgt = {$urandom() >> 2, 2'b00};
      end
      step(r, s, b, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0060: the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): the bubble encoding.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall_in  in  1  the pipeline is frozen, so the IF/ID outputs shall hold.
REQ-006 br_en  in  1  redirect request from EX (taken branch or jump).
REQ-007 br_target  in  32  redirect address, valid when br_en=1.
REQ-008 icache_read  out  1  I-cache read request.
REQ-009 icache_address  out  32  I-cache read address.
REQ-010 icache_rdata  in  32  fetched instruction, valid when icache_resp=1.
REQ-011 icache_resp  in  1  one-cycle response pulse for the outstanding read.
REQ-012 PC_out  out  32  registered PC of instruction_out (this is the decode PC input).
REQ-013 instruction_out  out  32  registered instruction (this is the decode instruction input).
REQ-014 valid_out  out  1  instruction_out is a real instruction, not a bubble.
REQ-015 fetch_stall  out  1  IF has no instruction ready this cycle, so the pipeline shall stall.

Function
REQ-016 The block shall contain a PC register pc, a request-address register req_addr, a hold buffer (hold_pc, hold_instr) and a 3-state FSM: FETCH, DRAIN and HOLD.
REQ-017 In FETCH, icache_read shall be 1 and icache_address shall be pc; req_addr shall be loaded with pc on every FETCH cycle.
REQ-018 In DRAIN, icache_read shall be 1 and icache_address shall be req_addr, so the address stays stable until the response arrives.
REQ-019 In HOLD, icache_read shall be 0.
REQ-020 icache_read and icache_address shall not change while a request is outstanding, except on rst.
REQ-021 FETCH, resp=1, br_en=0, stall_in=0: PC_out<=pc, instruction_out<=icache_rdata, valid_out<=1, pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), next state FETCH.
REQ-022 FETCH, resp=1, br_en=0, stall_in=1: hold_pc<=pc, hold_instr<=icache_rdata, pc<=pc+4, the IF/ID outputs hold, next state HOLD.
REQ-023 FETCH, resp=1, br_en=1: icache_rdata shall be discarded, pc<=br_target, IF/ID shall be flushed, next state FETCH.
REQ-024 FETCH, resp=0, br_en=1: pc<=br_target, IF/ID shall be flushed, next state DRAIN.
REQ-025 FETCH, resp=0, br_en=0: pc shall be unchanged; if stall_in=0, IF/ID<=bubble; if stall_in=1, IF/ID holds.
REQ-026 DRAIN, resp=1: icache_rdata shall be discarded, next state FETCH.
REQ-027 A further br_en=1 in DRAIN shall reload pc<=br_target without leaving DRAIN.
REQ-028 HOLD, br_en=1: the hold buffer shall be dropped, pc<=br_target, IF/ID shall be flushed, next state FETCH.
REQ-029 HOLD, br_en=0, stall_in=0: PC_out<=hold_pc, instruction_out<=hold_instr, valid_out<=1, next state FETCH.
REQ-030 HOLD, br_en=0, stall_in=1: all state shall remain unchanged.
REQ-031 A flush (bubble) is defined as PC_out<=0, instruction_out<=NOP_INSTR, valid_out<=0.
REQ-032 br_en shall take priority over stall_in: a flush occurs even while stall_in=1.
REQ-033 br_en may stay high for several cycles with the same target; each such cycle shall behave idempotently.
REQ-034 fetch_stall shall be 1 exactly when state is FETCH or DRAIN and no instruction is delivered to IF/ID in that cycle.
REQ-035 fetch_stall shall be 0 in HOLD.
REQ-036 Steady-state throughput shall be one instruction per cycle when the I-cache returns resp in the same cycle as the request.

Reset
REQ-037 On rst=1, state<=FETCH, pc<=RESET_PC, req_addr<=RESET_PC, PC_out<=0, instruction_out<=NOP_INSTR, valid_out<=0, and the hold buffer<=0.
REQ-038 During the rst cycle, icache_read shall be forced to 0.
REQ-039 rst shall be shared with the I-cache, so no response survives a reset.
REQ-040 A reset mid-request shall abandon that request.
REQ-041 rst shall take priority over br_en, stall_in and icache_resp.

Verification
REQ-042 Reset, then same-cycle resp with instrs A,B,C -> fetch addresses 0x60, 0x64, 0x68; PC_out 0x60, 0x64, 0x68 on consecutive cycles; valid_out=1.
REQ-043 Request to 0x64 outstanding, br_en=1 with target 0x200, resp arrives 3 cycles later -> icache_address holds 0x64 throughout DRAIN; the response is discarded; the next request is to 0x200; valid_out stays 0 until the 0x200 instruction arrives.
REQ-044 resp with 0x00A00093 at pc 0x70 while stall_in=1 for 4 cycles -> outputs unchanged for those 4 cycles; on release PC_out=0x70, instruction_out=0x00A00093; the next fetch is 0x74.
REQ-045 HOLD state with br_en=1 and target 0x100 -> the buffer is dropped, IF/ID shows the bubble (0x00000013, valid 0), and the next request is to 0x100.
REQ-046 pc=0xFFFFFFFC, resp=1, no stall -> the next request is to 0x00000000.
REQ-047 rst asserted while a request to 0x80 is outstanding -> icache_read=0 during the reset cycle; the next request is to 0x60; outputs return to their reset values.
